// File: rtl/ad7799_pkg.sv
// rtl/ad7799_pkg.sv - AD7799 register selects, sequencer states and channel/config helpers
package ad7799_pkg;

    localparam logic [2:0] RS_COMM   = 3'd0;
    localparam logic [2:0] RS_STATUS = 3'd0;
    localparam logic [2:0] RS_MODE   = 3'd1;
    localparam logic [2:0] RS_CONFIG = 3'd2;
    localparam logic [2:0] RS_DATA   = 3'd3;
    localparam logic [2:0] RS_ID     = 3'd4;
    localparam logic [2:0] RS_IO     = 3'd5;
    localparam logic [2:0] RS_OFFSET = 3'd6;
    localparam logic [2:0] RS_FS     = 3'd7;

    typedef enum logic [3:0] {
        IDLE, RST_REQ, RST_WAIT, RST_DLY, CFG_REQ, CFG_WAIT, CONV_REQ, CONV_WAIT, NEXT
    } seq_state_t;

    // CONFIG register layout: U/B at bit 12, gain at 10:8, BUF at 4, channel at 2:0.
    function automatic logic [23:0] cfg_word(input logic unipolar, input logic [2:0] gain,
                                             input logic buf_en, input logic [1:0] ch);
        return {8'h00, 3'b000, unipolar, 1'b0, gain, 2'b00, 1'b0, buf_en, 1'b0, 1'b0, ch};
    endfunction

    function automatic logic [1:0] lowest_ch(input logic [2:0] mask);
        return mask[0] ? 2'd0 : (mask[1] ? 2'd1 : 2'd2);
    endfunction

    // Next enabled channel above cur, wrapping to the lowest enabled one.
    function automatic logic [1:0] next_ch(input logic [2:0] mask, input logic [1:0] cur);
        logic [1:0] r;
        logic       found;
        r     = lowest_ch(mask);
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!found && mask[i] && (i > int'(cur))) begin
                r     = 2'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ad7799_result_fifo.sv
// rtl/ad7799_result_fifo.sv - first-word-fall-through sync FIFO for tagged samples
// Ports: clk, reset (async high), push/din write side, pop/data read side
// (data reads 0 while empty), empty, full, count occupancy.
module ad7799_result_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign do_push = push && (!full || do_pop);
    assign data    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ad7799_scan_seq.sv
// rtl/ad7799_scan_seq.sv - AD7799 channel-scan sequencer with tagged result FIFO
// Ports: phy_clk/reset (async high); start/stop/cont and latched scan settings;
// drv_* request strobes and busy/ready/dout from the SPI driver; rd_en/rd_data/
// empty/full/count FIFO read side; running, sticky overrun and timeout status.
module ad7799_scan_seq
    import ad7799_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned RST_DELAY    = 2000,
    parameter int unsigned CONV_TIMEOUT = 1 << 20
) (
    input  logic                          phy_clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          cont,
    input  logic [2:0]                    ch_mask,
    input  logic [2:0]                    gain,
    input  logic [3:0]                    rate,
    input  logic                          unipolar,
    input  logic                          buf_en,
    output logic                          drv_wrreq,
    output logic                          drv_rdreq,
    output logic                          drv_reset_req,
    output logic                          drv_single_conv_req,
    output logic                          drv_cont_conv_req,
    output logic                          drv_conv_mode,
    output logic [2:0]                    drv_rs,
    output logic [23:0]                   drv_din,
    input  logic                          drv_busy,
    input  logic                          drv_ready,
    input  logic [23:0]                   drv_dout,
    input  logic                          rd_en,
    output logic [25:0]                   rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          running,
    output logic                          overrun,
    output logic                          timeout
);
    seq_state_t  state;
    logic [2:0]  mask_q;
    logic        cont_q;
    logic [2:0]  gain_q;
    logic [3:0]  rate_q;
    logic        uni_q;
    logic        buf_q;
    logic [1:0]  ch;
    logic        seen_busy;
    logic        stop_pend;
    logic [31:0] cnt;
    logic        fifo_push;

    assign drv_cont_conv_req = 1'b0;
    assign drv_conv_mode     = 1'b0;
    assign fifo_push         = (state == CONV_WAIT) && drv_ready;

    ad7799_result_fifo #(.WIDTH(26), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (phy_clk),
        .reset (reset),
        .push  (fifo_push),
        .din   ({ch, drv_dout}),
        .pop   (rd_en),
        .data  (rd_data),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            drv_wrreq           <= 1'b0;
            drv_rdreq           <= 1'b0;
            drv_reset_req       <= 1'b0;
            drv_single_conv_req <= 1'b0;
            drv_rs              <= '0;
            drv_din             <= '0;
            running             <= 1'b0;
            overrun             <= 1'b0;
            timeout             <= 1'b0;
            mask_q              <= '0;
            cont_q              <= 1'b0;
            gain_q              <= '0;
            rate_q              <= '0;
            uni_q               <= 1'b0;
            buf_q               <= 1'b0;
            ch                  <= '0;
            seen_busy           <= 1'b0;
            stop_pend           <= 1'b0;
            cnt                 <= '0;
        end else begin
            drv_wrreq           <= 1'b0;
            drv_rdreq           <= 1'b0;
            drv_reset_req       <= 1'b0;
            drv_single_conv_req <= 1'b0;
            if (running && stop) stop_pend <= 1'b1;
            // A same-cycle pop makes room, so only a full FIFO without pop drops.
            if (fifo_push && full && !rd_en) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (start && ch_mask != 3'b000) begin
                        mask_q    <= ch_mask;
                        cont_q    <= cont;
                        gain_q    <= gain;
                        rate_q    <= rate;
                        uni_q     <= unipolar;
                        buf_q     <= buf_en;
                        overrun   <= 1'b0;
                        timeout   <= 1'b0;
                        stop_pend <= 1'b0;
                        running   <= 1'b1;
                        state     <= RST_REQ;
                    end
                end
                RST_REQ: if (!drv_busy) begin
                    drv_reset_req <= 1'b1;
                    seen_busy     <= 1'b0;
                    state         <= RST_WAIT;
                end
                // Busy is registered in the driver, so it rises only after the
                // pulse cycle; wait for the rise before trusting a low level.
                RST_WAIT: begin
                    if (drv_busy) seen_busy <= 1'b1;
                    else if (seen_busy) begin
                        cnt   <= '0;
                        state <= RST_DLY;
                    end
                end
                RST_DLY: begin
                    if (cnt + 32'd1 >= RST_DELAY) begin
                        ch    <= lowest_ch(mask_q);
                        state <= CFG_REQ;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CFG_REQ: if (!drv_busy) begin
                    drv_wrreq <= 1'b1;
                    drv_rs    <= RS_CONFIG;
                    drv_din   <= cfg_word(uni_q, gain_q, buf_q, ch);
                    seen_busy <= 1'b0;
                    state     <= CFG_WAIT;
                end
                CFG_WAIT: begin
                    if (drv_busy) seen_busy <= 1'b1;
                    else if (seen_busy) state <= CONV_REQ;
                end
                CONV_REQ: if (!drv_busy) begin
                    drv_single_conv_req <= 1'b1;
                    drv_rs              <= RS_MODE;
                    drv_din             <= {20'h0, rate_q};
                    seen_busy           <= 1'b0;
                    cnt                 <= '0;
                    state               <= CONV_WAIT;
                end
                // The driver cannot be cancelled, so a timeout only flags.
                CONV_WAIT: begin
                    if (cnt >= CONV_TIMEOUT) timeout <= 1'b1;
                    else cnt <= cnt + 32'd1;
                    if (drv_busy) seen_busy <= 1'b1;
                    else if (seen_busy) state <= NEXT;
                end
                NEXT: begin
                    if (stop_pend || (next_ch(mask_q, ch) <= ch && !cont_q)) begin
                        running <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        ch    <= next_ch(mask_q, ch);
                        state <= CFG_REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
